// File: rtl/hmmm_loader_if.sv
// Stream and core-bus signal bundle between hmmm_loader (master) and its surroundings (slave).
interface hmmm_loader_if #(
    parameter int DATA_W = 16
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              pgrm_addr;
    logic              pgrm_data;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;

    modport master (
        input  in_data, in_valid,
        output in_ready, pgrm_addr, pgrm_data, bus_out, bus_oe
    );

    modport slave (
        output in_data, in_valid,
        input  in_ready, pgrm_addr, pgrm_data, bus_out, bus_oe
    );
endinterface

// File: rtl/hmmm_loader.sv
// Program loader / run sequencer for the hmmm core: byte stream -> core RAM, then run until halt.
// Optional trailing-checksum check is enabled by defining HMMM_LOADER_CHECKSUM_EN.
module hmmm_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_core_halt,
    output logic          o_core_rst,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_error,
    hmmm_loader_if.master bus
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_RESET = 4'd1;
    localparam logic [3:0] S_COUNT = 4'd2;
    localparam logic [3:0] S_HI    = 4'd3;
    localparam logic [3:0] S_LO    = 4'd4;
    localparam logic [3:0] S_ADDR  = 4'd5;
    localparam logic [3:0] S_DATA  = 4'd6;
    localparam logic [3:0] S_RUN   = 4'd8;
    localparam logic [3:0] S_DONE  = 4'd9;
    localparam logic [3:0] S_ERROR = 4'd10;
`ifdef HMMM_LOADER_CHECKSUM_EN
    localparam logic [3:0] S_CHECK = 4'd7;
    localparam logic [3:0] S_AFTER = S_CHECK;
`else
    localparam logic [3:0] S_AFTER = S_RUN;
`endif

    logic [3:0]        r_state,   w_state_next;
    logic [ADDR_W-1:0] r_wp,      w_wp_next;
    logic [ADDR_W-1:0] r_n,       w_n_next;
    logic [DATA_W-1:0] r_word,    w_word_next;
    logic              r_done,    w_done_next;
`ifdef HMMM_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum,    w_csum_next;
    logic              r_error,   w_error_next;
`endif

    logic              r_in_ready, w_in_ready_next;
    logic              r_core_rst, w_core_rst_next;
    logic              r_pgrm_addr, w_pgrm_addr_next;
    logic              r_pgrm_data, w_pgrm_data_next;
    logic              r_bus_oe,   w_bus_oe_next;
    logic [DATA_W-1:0] r_bus_out,  w_bus_out_next;
    logic              r_busy,     w_busy_next;

    logic              w_xfer;
    logic [ADDR_W-1:0] w_wp_inc;

    assign w_xfer   = bus.in_valid & r_in_ready;
    assign w_wp_inc = r_wp + ADDR_W'(1);

    always_comb begin
        w_state_next = r_state;
        w_wp_next    = r_wp;
        w_n_next     = r_n;
        w_word_next  = r_word;
        w_done_next  = r_done;
`ifdef HMMM_LOADER_CHECKSUM_EN
        w_csum_next  = r_csum;
        w_error_next = r_error;
`endif
        case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (i_load) begin
                    w_state_next = S_RESET;
                    w_done_next  = 1'b0;
`ifdef HMMM_LOADER_CHECKSUM_EN
                    w_error_next = 1'b0;
`endif
                end
            end
            S_RESET: begin
                w_state_next = S_COUNT;
                w_wp_next    = '0;
                w_n_next     = '0;
`ifdef HMMM_LOADER_CHECKSUM_EN
                w_csum_next  = 8'h00;
`endif
            end
            S_COUNT: begin
                if (w_xfer) begin
                    w_n_next     = ADDR_W'(bus.in_data);
                    w_state_next = (bus.in_data == 8'h00) ? S_AFTER : S_HI;
`ifdef HMMM_LOADER_CHECKSUM_EN
                    w_csum_next  = bus.in_data;
`endif
                end
            end
            S_HI: begin
                if (w_xfer) begin
                    w_word_next[15:8] = bus.in_data;
                    w_state_next      = S_LO;
`ifdef HMMM_LOADER_CHECKSUM_EN
                    w_csum_next       = r_csum ^ bus.in_data;
`endif
                end
            end
            S_LO: begin
                if (w_xfer) begin
                    w_word_next[7:0] = bus.in_data;
                    w_state_next     = S_ADDR;
`ifdef HMMM_LOADER_CHECKSUM_EN
                    w_csum_next      = r_csum ^ bus.in_data;
`endif
                end
            end
            S_ADDR: w_state_next = S_DATA;
            S_DATA: begin
                w_wp_next    = w_wp_inc;
                w_state_next = (w_wp_inc == r_n) ? S_AFTER : S_HI;
            end
`ifdef HMMM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (w_xfer) begin
                    if (bus.in_data == r_csum) begin
                        w_state_next = S_RUN;
                    end else begin
                        w_state_next = S_ERROR;
                        w_error_next = 1'b1;
                    end
                end
            end
`endif
            S_RUN: begin
                // halt is only meaningful once the core has been released
                if (i_core_halt) begin
                    w_state_next = S_DONE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every one of them is a flop.
    always_comb begin
        w_in_ready_next  = 1'b0;
        w_core_rst_next  = 1'b0;
        w_pgrm_addr_next = 1'b0;
        w_pgrm_data_next = 1'b0;
        w_bus_oe_next    = 1'b0;
        w_bus_out_next   = '0;
        w_busy_next      = 1'b1;
        case (w_state_next)
            S_IDLE, S_DONE, S_ERROR: w_busy_next = 1'b0;
            S_RESET:                 w_core_rst_next = 1'b1;
            S_COUNT, S_HI, S_LO:     w_in_ready_next = 1'b1;
`ifdef HMMM_LOADER_CHECKSUM_EN
            S_CHECK:                 w_in_ready_next = 1'b1;
`endif
            S_ADDR: begin
                w_pgrm_addr_next = 1'b1;
                w_bus_oe_next    = 1'b1;
                w_bus_out_next   = DATA_W'(w_wp_next);
            end
            S_DATA: begin
                w_pgrm_data_next = 1'b1;
                w_bus_oe_next    = 1'b1;
                w_bus_out_next   = w_word_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wp        <= '0;
            r_n         <= '0;
            r_word      <= '0;
            r_done      <= 1'b0;
`ifdef HMMM_LOADER_CHECKSUM_EN
            r_csum      <= 8'h00;
            r_error     <= 1'b0;
`endif
            r_in_ready  <= 1'b0;
            r_core_rst  <= 1'b0;
            r_pgrm_addr <= 1'b0;
            r_pgrm_data <= 1'b0;
            r_bus_oe    <= 1'b0;
            r_bus_out   <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_wp        <= w_wp_next;
            r_n         <= w_n_next;
            r_word      <= w_word_next;
            r_done      <= w_done_next;
`ifdef HMMM_LOADER_CHECKSUM_EN
            r_csum      <= w_csum_next;
            r_error     <= w_error_next;
`endif
            r_in_ready  <= w_in_ready_next;
            r_core_rst  <= w_core_rst_next;
            r_pgrm_addr <= w_pgrm_addr_next;
            r_pgrm_data <= w_pgrm_data_next;
            r_bus_oe    <= w_bus_oe_next;
            r_bus_out   <= w_bus_out_next;
            r_busy      <= w_busy_next;
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.pgrm_addr = r_pgrm_addr;
    assign bus.pgrm_data = r_pgrm_data;
    assign bus.bus_oe    = r_bus_oe;
    assign bus.bus_out   = r_bus_out;
    assign o_core_rst    = r_core_rst;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
`ifdef HMMM_LOADER_CHECKSUM_EN
    assign o_error       = r_error;
`else
    assign o_error       = 1'b0;
`endif

endmodule
